systolic_tile_streamer: RTL and testbench
=========================================

# systolic_tile_streamer

Parametrised two-channel matrix-slice source for the systolic array. It streams Matrix A and Matrix B slices from two synchronous-read memory ports, using base addresses and beat counts configured at run time. Each region can be replayed a configured number of times. It replaces fixed-size, file-loaded slice generation with a synthesizable, backpressure-safe streamer. It sits between the weight/image buffers and the systolic array input ports.

## Interface
Parameters:
- DATA_WIDTH, 64, slice beat width
- ADDR_WIDTH, 16, memory word-address width
- CNT_WIDTH, 16, beat-count width
- REP_WIDTH, 8, repeat-count width

Ports (s_clk and s_rst first; s_clk is the clock, s_rst is asynchronous and active-high):
- s_clk  in  1  clock
- s_rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle launch; ignored while busy=1
- cfg_a_base  in  ADDR_WIDTH  Matrix A first word address
- cfg_a_beats  in  CNT_WIDTH  Matrix A beats per pass
- cfg_b_base  in  ADDR_WIDTH  Matrix B first word address
- cfg_b_beats  in  CNT_WIDTH  Matrix B beats per pass
- cfg_repeat  in  REP_WIDTH  extra passes per channel; total passes = cfg_repeat+1
- busy  out  1  high from the cycle after start until both channels are done
- mtrxA_valid, mtrxA_ready, mtrxA_data[DATA_WIDTH], mtrxA_last  out/in/out/out  Matrix A stream; last marks the final beat of each pass
- mtrxA_done  out  1  one-cycle pulse after the final beat of the final pass
- mtrxB_valid, mtrxB_ready, mtrxB_data, mtrxB_last, mtrxB_done  same as Matrix A, for Matrix B
- memA_rd_en, memA_rd_addr[ADDR_WIDTH]  out  Matrix A memory read request
- memA_rd_data[DATA_WIDTH]  in  Matrix A read data, valid exactly 1 cycle after memA_rd_en
- memB_rd_en, memB_rd_addr, memB_rd_data  same as Matrix A, for Matrix B

## Operation
- At start, the configuration is latched into per-channel registers. Later cfg_* changes do not affect the transfer in flight.
- Each channel runs independently with FSM states IDLE, FETCH, DRAIN, DONE:
  - IDLE to FETCH on start.
  - FETCH issues reads at base, base+1, …, base+beats-1, then wraps to base for the next pass.
  - FETCH to DRAIN when all reads for all passes have been issued.
  - DRAIN to DONE when the output buffer is empty and the final handshake has occurred.
  - DONE pulses done for 1 cycle and returns to IDLE.
- Output buffer: 2-entry FIFO per channel.
  - A read issues only when (reads in flight + occupancy) < 2, so data is never dropped.
  - valid = FIFO not empty. The data, last and valid outputs come directly from the FIFO head.
- last is a tag stored with each read: asserted when the beat index equals beats-1.
- Beat index and pass counters are CNT_WIDTH and REP_WIDTH wide. Address computation base+index wraps modulo 2^ADDR_WIDTH.
- beats=0: no reads and no valid; done pulses 2 cycles after start, and the channel counts as finished.
- busy falls in the cycle after the later of the two done pulses.
- Reset (including mid-transfer): FSMs go to IDLE, the FIFOs flush, and in-flight read data is discarded.

## Timing
- Reset values: every valid, last, done, busy and rd_en output is 0. rd_addr and data are 0.
- Start latency with ready held high:
  - start at cycle T.
  - First rd_en at T+1.
  - First valid at T+2.
  - Sustained throughput is 1 beat per cycle.
- Handshake: a beat transfers when valid and ready are both high.
  - Once valid rises, valid and data hold until the transfer.
  - valid does not depend combinationally on ready.
- When ready drops, at most 2 beats are buffered. rd_en falls in the same cycle the FIFO would overflow.
- Full-speed restart: with ready held high, beats continue across a pass wrap with no bubble.
- A done pulse occurs 1 cycle after the final handshake.
- A start that coincides with done (channel not yet IDLE) is ignored.

## Configuration
- SA_STALL_CNT_EN defined: adds ports stall_cnt_a and stall_cnt_b, each out, 32 bits.
  - Each counts cycles with valid=1 and ready=0 for its channel.
  - Both clear on start and saturate at all-ones.
- SA_STALL_CNT_EN undefined: these ports and their counters are absent. Stream behaviour is identical.

## Structure
- Package sa_stream_pkg holds:
  - the channel FSM state enum (IDLE, FETCH, DRAIN, DONE);
  - the FIFO depth constant (2);
  - default widths.
- Sub-module sa_slice_channel implements one channel: FSM, counters, credit logic and the 2-entry FIFO. It is instantiated twice.
- The top level handles start gating, busy and the optional stall counters.

## Test plan
- Ready held high, A base 0x0000 with 512 beats, B base 0x1000 with 512 beats, repeat 0 → 512 consecutive beats per channel, with first valid at T+2. last is set on beat 511; done is seen at the final handshake +1 and busy falls 1 cycle later.
- A with 4 beats and repeat 2 → A address sequence 0,1,2,3 ×3 with no gap at the wraps. last fires 3 times and done fires once.
- Random ready (50%) on B with 64 beats → data matches memory order, valid is never withdrawn, no beat is lost or duplicated, and there are at most 2 reads in flight or buffered.
- A with 0 beats and B with 8 beats → A shows no valid and done at T+2; busy stays high until B's done +1.
- s_rst asserted mid-pass at beat 100 → all outputs 0 immediately. A new start then replays from base.
- SA_STALL_CNT_EN defined, ready low for 10 cycles while valid is high → stall counter reads 10. It reads 0 after the next start.

Source files
------------

// File: rtl/sa_stream_pkg.sv
// Shared types and constants for the systolic tile streamer.
package sa_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chan_state_t;

  localparam int FIFO_DEPTH     = 2;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_REP_WIDTH  = 8;

endpackage

// File: rtl/sa_slice_channel.sv
// One streaming channel: fetch FSM, beat/pass counters, read credits and a 2-entry output FIFO.
// FIFO slots are allocated at read issue, so a slot whose data is landing this cycle is read straight from the memory port.
module sa_slice_channel
  import sa_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int REP_WIDTH  = DEF_REP_WIDTH
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  launch,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [CNT_WIDTH-1:0]  cfg_beats,
  input  logic [REP_WIDTH-1:0]  cfg_repeat,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  done,
  output logic                  idle,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  chan_state_t           state_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [CNT_WIDTH-1:0]  beats_r;
  logic [CNT_WIDTH-1:0]  idx_r;
  logic [REP_WIDTH-1:0]  rep_r;
  logic [REP_WIDTH-1:0]  pass_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] buf_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] buf_last_r;
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic                  land_r;
  logic                  land_ptr_r;
  logic [1:0]            count_r;
  logic                  pop_s;
  logic                  issue_s;
  logic                  last_beat_s;
  logic                  head_land_s;

  // A popping slot may be re-issued in the same cycle, which sustains one beat per cycle.
  always_comb begin
    pop_s       = (count_r != 2'd0) && ready;
    issue_s     = (state_r == FETCH) && ((count_r < 2'(FIFO_DEPTH)) || pop_s);
    last_beat_s = (idx_r == (beats_r - CNT_WIDTH'(1)));
    head_land_s = land_r && (land_ptr_r == rd_ptr_r);
  end

  assign valid   = (count_r != 2'd0);
  assign data    = head_land_s ? rd_data : buf_data_r[rd_ptr_r];
  assign last    = buf_last_r[rd_ptr_r];
  assign done    = done_r;
  assign idle    = (state_r == IDLE);
  assign rd_en   = issue_s;
  assign rd_addr = base_r + ADDR_WIDTH'(idx_r);

  // FIFO storage, pointers and landing tracker for the one-cycle read latency.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) buf_data_r[i] <= '0;
      buf_last_r <= '0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      land_r     <= 1'b0;
      land_ptr_r <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      land_r     <= issue_s;
      land_ptr_r <= wr_ptr_r;
      if (land_r) buf_data_r[land_ptr_r] <= rd_data;
      if (issue_s) begin
        buf_last_r[wr_ptr_r] <= last_beat_s;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, issue_s} - {1'b0, pop_s};
    end
  end

  // Channel FSM with beat/pass counters and registered done pulse.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_r <= IDLE;
      base_r  <= '0;
      beats_r <= '0;
      rep_r   <= '0;
      idx_r   <= '0;
      pass_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (launch) begin
            base_r  <= cfg_base;
            beats_r <= cfg_beats;
            rep_r   <= cfg_repeat;
            idx_r   <= '0;
            pass_r  <= '0;
            state_r <= (cfg_beats == '0) ? DRAIN : FETCH;
          end
        end
        FETCH: begin
          if (issue_s) begin
            if (last_beat_s) begin
              idx_r <= '0;
              if (pass_r == rep_r) state_r <= DRAIN;
              else pass_r <= pass_r + REP_WIDTH'(1);
            end else begin
              idx_r <= idx_r + CNT_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/systolic_tile_streamer.sv
// Two-channel Matrix A/B slice streamer: start gating, busy tracking and two sa_slice_channel instances.
// Optional SA_STALL_CNT_EN adds per-channel 32-bit saturating stall counters.
module systolic_tile_streamer
  import sa_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int REP_WIDTH  = DEF_REP_WIDTH
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_a_base,
  input  logic [CNT_WIDTH-1:0]  cfg_a_beats,
  input  logic [ADDR_WIDTH-1:0] cfg_b_base,
  input  logic [CNT_WIDTH-1:0]  cfg_b_beats,
  input  logic [REP_WIDTH-1:0]  cfg_repeat,
  output logic                  busy,
  output logic                  mtrxA_valid,
  input  logic                  mtrxA_ready,
  output logic [DATA_WIDTH-1:0] mtrxA_data,
  output logic                  mtrxA_last,
  output logic                  mtrxA_done,
  output logic                  mtrxB_valid,
  input  logic                  mtrxB_ready,
  output logic [DATA_WIDTH-1:0] mtrxB_data,
  output logic                  mtrxB_last,
  output logic                  mtrxB_done,
`ifdef SA_STALL_CNT_EN
  output logic [31:0]           stall_cnt_a,
  output logic [31:0]           stall_cnt_b,
`endif
  output logic                  memA_rd_en,
  output logic [ADDR_WIDTH-1:0] memA_rd_addr,
  input  logic [DATA_WIDTH-1:0] memA_rd_data,
  output logic                  memB_rd_en,
  output logic [ADDR_WIDTH-1:0] memB_rd_addr,
  input  logic [DATA_WIDTH-1:0] memB_rd_data
);

  logic busy_r;
  logic fin_a_r;
  logic fin_b_r;
  logic idle_a_s;
  logic idle_b_s;
  logic launch_s;

  assign launch_s = start && !busy_r && idle_a_s && idle_b_s;
  assign busy     = busy_r;

  sa_slice_channel #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH), .REP_WIDTH(REP_WIDTH)
  ) u_chan_a (
    .s_clk(s_clk), .s_rst(s_rst), .launch(launch_s),
    .cfg_base(cfg_a_base), .cfg_beats(cfg_a_beats), .cfg_repeat(cfg_repeat),
    .valid(mtrxA_valid), .ready(mtrxA_ready), .data(mtrxA_data), .last(mtrxA_last),
    .done(mtrxA_done), .idle(idle_a_s),
    .rd_en(memA_rd_en), .rd_addr(memA_rd_addr), .rd_data(memA_rd_data)
  );

  sa_slice_channel #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH), .REP_WIDTH(REP_WIDTH)
  ) u_chan_b (
    .s_clk(s_clk), .s_rst(s_rst), .launch(launch_s),
    .cfg_base(cfg_b_base), .cfg_beats(cfg_b_beats), .cfg_repeat(cfg_repeat),
    .valid(mtrxB_valid), .ready(mtrxB_ready), .data(mtrxB_data), .last(mtrxB_last),
    .done(mtrxB_done), .idle(idle_b_s),
    .rd_en(memB_rd_en), .rd_addr(memB_rd_addr), .rd_data(memB_rd_data)
  );

  // Busy drops the cycle after whichever channel finishes last.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      busy_r  <= 1'b0;
      fin_a_r <= 1'b0;
      fin_b_r <= 1'b0;
    end else if (launch_s) begin
      busy_r  <= 1'b1;
      fin_a_r <= 1'b0;
      fin_b_r <= 1'b0;
    end else begin
      if (busy_r && (fin_a_r || mtrxA_done) && (fin_b_r || mtrxB_done)) busy_r <= 1'b0;
      if (mtrxA_done) fin_a_r <= 1'b1;
      if (mtrxB_done) fin_b_r <= 1'b1;
    end
  end

`ifdef SA_STALL_CNT_EN
  // Saturating count of cycles where a beat is offered but not taken.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      stall_cnt_a <= 32'd0;
      stall_cnt_b <= 32'd0;
    end else if (launch_s) begin
      stall_cnt_a <= 32'd0;
      stall_cnt_b <= 32'd0;
    end else begin
      if (mtrxA_valid && !mtrxA_ready && (stall_cnt_a != 32'hFFFF_FFFF)) stall_cnt_a <= stall_cnt_a + 32'd1;
      if (mtrxB_valid && !mtrxB_ready && (stall_cnt_b != 32'hFFFF_FFFF)) stall_cnt_b <= stall_cnt_b + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_streamer.sv
// Table-driven bench with a per-channel scoreboard queue for systolic_tile_streamer.
module tb_systolic_tile_streamer;

  typedef struct {
    logic [15:0] a_base;
    logic [15:0] a_beats;
    logic [15:0] b_base;
    logic [15:0] b_beats;
    logic [7:0]  rep;
    int          b_rand;
    int          restart_at;
    int          exp_a_done;
    int          exp_b_done;
    int          exp_busy_fall;
    int          exp_a_last;
    int          exp_b_last;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic        s_clk = 1'b0;
  logic        s_rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_a_base = 16'd0, cfg_a_beats = 16'd0, cfg_b_base = 16'd0, cfg_b_beats = 16'd0;
  logic [7:0]  cfg_repeat = 8'd0;
  logic        busy;
  logic        mtrxA_valid, mtrxA_ready = 1'b1, mtrxA_last, mtrxA_done;
  logic        mtrxB_valid, mtrxB_ready = 1'b1, mtrxB_last, mtrxB_done;
  logic [63:0] mtrxA_data, mtrxB_data;
  logic        memA_rd_en, memB_rd_en;
  logic [15:0] memA_rd_addr, memB_rd_addr;
  logic [63:0] memA_rd_data = 64'd0, memB_rd_data = 64'd0;
`ifdef SA_STALL_CNT_EN
  logic [31:0] stall_cnt_a, stall_cnt_b;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   off;
  bit   mon_on = 1'b0;
  int   rmode [2];
  int   first_rd [2], first_valid [2], done_n [2], done_at [2], last_n [2];
  int   out_n [2], max_out [2], withdraw [2], hs_n [2];
  logic [15:0] first_addr [2];
  logic prev_v [2], prev_r [2];
  logic [63:0] prev_d [2];
  logic prev_busy;
  int   busy_fall;
  exp_t qa [$];
  exp_t qb [$];
  vec_t vecs [5];

  systolic_tile_streamer dut (
    .s_clk(s_clk), .s_rst(s_rst), .start(start),
    .cfg_a_base(cfg_a_base), .cfg_a_beats(cfg_a_beats),
    .cfg_b_base(cfg_b_base), .cfg_b_beats(cfg_b_beats), .cfg_repeat(cfg_repeat),
    .busy(busy),
    .mtrxA_valid(mtrxA_valid), .mtrxA_ready(mtrxA_ready), .mtrxA_data(mtrxA_data),
    .mtrxA_last(mtrxA_last), .mtrxA_done(mtrxA_done),
    .mtrxB_valid(mtrxB_valid), .mtrxB_ready(mtrxB_ready), .mtrxB_data(mtrxB_data),
    .mtrxB_last(mtrxB_last), .mtrxB_done(mtrxB_done),
`ifdef SA_STALL_CNT_EN
    .stall_cnt_a(stall_cnt_a), .stall_cnt_b(stall_cnt_b),
`endif
    .memA_rd_en(memA_rd_en), .memA_rd_addr(memA_rd_addr), .memA_rd_data(memA_rd_data),
    .memB_rd_en(memB_rd_en), .memB_rd_addr(memB_rd_addr), .memB_rd_data(memB_rd_data)
  );

  always #5 s_clk = ~s_clk;
  always @(posedge s_clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic ch, input logic [15:0] a);
    return {(ch ? 16'hB00B : 16'hA00A), ~a, a ^ 16'h5A5A, a};
  endfunction

  // Synchronous-read memory models, data one cycle after rd_en.
  always @(posedge s_clk) begin
    if (memA_rd_en) memA_rd_data <= mem_word(1'b0, memA_rd_addr);
    if (memB_rd_en) memB_rd_data <= mem_word(1'b1, memB_rd_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    rmode[0] = 0;
    rmode[1] = 0;
    forever begin
      @(posedge s_clk);
      #1;
      mtrxA_ready = (rmode[0] == 0) ? 1'b1 : (rmode[0] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      mtrxB_ready = (rmode[1] == 0) ? 1'b1 : (rmode[1] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic mon_chan(input int ch, input logic v, input logic r, input logic [63:0] d,
                          input logic l, input logic re, input logic [15:0] ra, input logic dn);
    exp_t e;
    logic hs;
    hs = v && r;
    if (re && first_rd[ch] < 0) begin
      first_rd[ch]   = off;
      first_addr[ch] = ra;
    end
    if (v && first_valid[ch] < 0) first_valid[ch] = off;
    if (dn) begin
      done_n[ch]++;
      done_at[ch] = off;
    end
    if (prev_v[ch] && !prev_r[ch] && (!v || d !== prev_d[ch])) withdraw[ch]++;
    out_n[ch] = out_n[ch] + int'(re) - int'(hs);
    if (out_n[ch] > max_out[ch]) max_out[ch] = out_n[ch];
    if (hs) begin
      hs_n[ch]++;
      if ((ch == 0 && qa.size() == 0) || (ch == 1 && qb.size() == 0)) begin
        chk($sformatf("ch%0d_extra_beat", ch), 64'd1, 64'd0);
      end else begin
        if (ch == 0) e = qa.pop_front();
        else e = qb.pop_front();
        chk($sformatf("ch%0d_data", ch), d, e.data);
        chk($sformatf("ch%0d_last", ch), {63'd0, l}, {63'd0, e.last});
        if (l) last_n[ch]++;
      end
    end
    prev_v[ch] = v;
    prev_r[ch] = r;
    prev_d[ch] = d;
  endtask

  initial begin
    forever begin
      @(negedge s_clk);
      if (!s_rst && mon_on) begin
        off = cyc - t0;
        mon_chan(0, mtrxA_valid, mtrxA_ready, mtrxA_data, mtrxA_last, memA_rd_en, memA_rd_addr, mtrxA_done);
        mon_chan(1, mtrxB_valid, mtrxB_ready, mtrxB_data, mtrxB_last, memB_rd_en, memB_rd_addr, mtrxB_done);
        if (prev_busy && !busy && busy_fall < 0) busy_fall = off;
        prev_busy = busy;
      end
    end
  end

  task automatic push_exp(input int ch, input logic [15:0] base, input logic [15:0] beats, input logic [7:0] rep);
    exp_t e;
    for (int p = 0; p <= int'(rep); p++) begin
      for (int i = 0; i < int'(beats); i++) begin
        e.data = mem_word(ch[0], base + 16'(i));
        e.last = (i == int'(beats) - 1);
        if (ch == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
  endtask

  task automatic begin_run(input vec_t v);
    for (int ch = 0; ch < 2; ch++) begin
      first_rd[ch] = -1; first_valid[ch] = -1; done_n[ch] = 0; done_at[ch] = -1; last_n[ch] = 0;
      out_n[ch] = 0; max_out[ch] = 0; withdraw[ch] = 0; hs_n[ch] = 0; first_addr[ch] = 16'd0;
      prev_v[ch] = 1'b0; prev_r[ch] = 1'b0; prev_d[ch] = 64'd0;
    end
    prev_busy = 1'b0;
    busy_fall = -1;
    push_exp(0, v.a_base, v.a_beats, v.rep);
    push_exp(1, v.b_base, v.b_beats, v.rep);
    rmode[1] = v.b_rand;
    @(posedge s_clk);
    #1;
    cfg_a_base = v.a_base; cfg_a_beats = v.a_beats;
    cfg_b_base = v.b_base; cfg_b_beats = v.b_beats; cfg_repeat = v.rep;
    start = 1'b1;
    t0 = cyc;
    mon_on = 1'b1;
    @(posedge s_clk);
    #1;
    start = 1'b0;
    cfg_a_base = 16'($urandom); cfg_a_beats = 16'($urandom); cfg_b_base = 16'($urandom);
    cfg_b_beats = 16'($urandom); cfg_repeat = 8'($urandom);
  endtask

  task automatic wait_done(input int restart_at);
    int c;
    c = 1;
    while (busy_fall < 0 && c < 3000) begin
      @(posedge s_clk);
      #1;
      c++;
      start = (restart_at > 0) && (c == restart_at);
    end
    start = 1'b0;
    if (busy_fall < 0) chk("busy_fall_timeout", 64'd1, 64'd0);
    repeat (2) @(posedge s_clk);
    #1;
    mon_on = 1'b0;
    rmode[1] = 0;
  endtask

  task automatic end_checks(input vec_t v, input int id);
    for (int ch = 0; ch < 2; ch++) begin
      logic [15:0] beats;
      logic [15:0] base;
      int          exp_done;
      int          exp_last;
      beats    = (ch == 0) ? v.a_beats : v.b_beats;
      base     = (ch == 0) ? v.a_base : v.b_base;
      exp_done = (ch == 0) ? v.exp_a_done : v.exp_b_done;
      exp_last = (ch == 0) ? v.exp_a_last : v.exp_b_last;
      chk($sformatf("v%0d_ch%0d_left", id, ch), 64'((ch == 0) ? qa.size() : qb.size()), 64'd0);
      chk($sformatf("v%0d_ch%0d_done_n", id, ch), 64'(done_n[ch]), 64'd1);
      if (exp_done >= 0) chk($sformatf("v%0d_ch%0d_done_at", id, ch), 64'(done_at[ch]), 64'(exp_done));
      chk($sformatf("v%0d_ch%0d_last_n", id, ch), 64'(last_n[ch]), 64'(exp_last));
      chk($sformatf("v%0d_ch%0d_max_out", id, ch), 64'(max_out[ch] <= 2), 64'd1);
      chk($sformatf("v%0d_ch%0d_withdraw", id, ch), 64'(withdraw[ch]), 64'd0);
      if (beats != 16'd0) begin
        chk($sformatf("v%0d_ch%0d_first_rd", id, ch), 64'(first_rd[ch]), 64'd1);
        chk($sformatf("v%0d_ch%0d_first_addr", id, ch), 64'(first_addr[ch]), 64'(base));
        chk($sformatf("v%0d_ch%0d_first_valid", id, ch), 64'(first_valid[ch]), 64'd2);
      end else begin
        chk($sformatf("v%0d_ch%0d_no_rd", id, ch), 64'(first_rd[ch] < 0), 64'd1);
        chk($sformatf("v%0d_ch%0d_no_valid", id, ch), 64'(first_valid[ch] < 0), 64'd1);
      end
    end
    if (v.exp_busy_fall >= 0) chk($sformatf("v%0d_busy_fall", id), 64'(busy_fall), 64'(v.exp_busy_fall));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_flags"}, {56'd0, mtrxA_valid, mtrxA_last, mtrxA_done, mtrxB_valid, mtrxB_last,
                          mtrxB_done, memA_rd_en, memB_rd_en}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_addr"}, {32'd0, memA_rd_addr, memB_rd_addr}, 64'd0);
    chk({tag, "_data_a"}, mtrxA_data, 64'd0);
    chk({tag, "_data_b"}, mtrxB_data, 64'd0);
  endtask

  initial begin
    vec_t v;
    int   n;
    vecs[0] = '{16'h0000, 16'd512, 16'h1000, 16'd512, 8'd0, 0, 0, 514, 514, 515, 1, 1};
    vecs[1] = '{16'h0000, 16'd4,   16'h2000, 16'd3,   8'd2, 0, 0, 14,  11,  15,  3, 3};
    vecs[2] = '{16'h0100, 16'd16,  16'h3000, 16'd64,  8'd0, 1, 0, 18,  -1,  -1,  1, 1};
    vecs[3] = '{16'h0000, 16'd0,   16'h0040, 16'd8,   8'd0, 0, 2, 2,   10,  11,  0, 1};
    vecs[4] = '{16'hFFFE, 16'd4,   16'hFFFF, 16'd1,   8'd1, 0, 0, 10,  4,   11,  2, 2};

    #2;
    chk_outputs_zero("reset");
    repeat (3) @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    @(posedge s_clk);
    #1;
    chk_outputs_zero("post_reset");

    for (int i = 0; i < 5; i++) begin
      begin_run(vecs[i]);
      wait_done(vecs[i].restart_at);
      end_checks(vecs[i], i);
    end

    // Reset in the middle of a long pass, then replay from base.
    begin_run(vecs[0]);
    n = 0;
    while (hs_n[0] < 100 && n < 400) begin
      @(posedge s_clk);
      #1;
      n++;
    end
    chk("mid_reset_reach_beat100", 64'(hs_n[0] >= 100), 64'd1);
    s_rst = 1'b1;
    #1;
    chk_outputs_zero("mid_reset");
    mon_on = 1'b0;
    qa.delete();
    qb.delete();
    @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    begin_run(vecs[1]);
    wait_done(0);
    end_checks(vecs[1], 10);

`ifdef SA_STALL_CNT_EN
    v = '{16'h0200, 16'd8, 16'h0000, 16'd0, 8'd0, 0, 0, -1, -1, -1, 1, 0};
    rmode[0] = 2;
    begin_run(v);
    n = 0;
    while (n < 20) begin
      @(negedge s_clk);
      if (mtrxA_valid) break;
      n++;
    end
    repeat (10) @(posedge s_clk);
    #1;
    rmode[0] = 0;
    mtrxA_ready = 1'b1;
    wait_done(0);
    end_checks(v, 20);
    chk("stall_cnt_a", 64'(stall_cnt_a), 64'd10);
    chk("stall_cnt_b", 64'(stall_cnt_b), 64'd0);
    v.a_beats = 16'd2;
    begin_run(v);
    chk("stall_cnt_a_cleared", 64'(stall_cnt_a), 64'd0);
    wait_done(0);
`else
    v = vecs[4];
    v.a_beats = 16'd2;
`endif
    chk("final_busy", {63'd0, busy}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
